// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// A slot record describes one in-flight writer: whether the slot holds an
// instruction, whether it writes a register, which register, and the first
// stage whose output carries the result.
package fwd_pkg;

  // Widest register address a slot can hold; narrower addresses are zero-extended.
  localparam int unsigned REG_AW_MAX = 8;

  // Forwarding select values.
  localparam int unsigned FWD_SEL_RF = 0;
  localparam int unsigned STG_EX     = 1;
  localparam int unsigned STG_MEM    = 2;
  localparam int unsigned STG_WB     = 3;

  // rdy_stg encodings for the common result producers.
  localparam logic [2:0] RDY_ALU  = 3'd1;
  localparam logic [2:0] RDY_LOAD = 3'd2;

  typedef struct packed {
    logic                  valid;
    logic                  we;
    logic [REG_AW_MAX-1:0] rd;
    logic [2:0]            rdy_stg;
  } slot_t;

  localparam slot_t SLOT_EMPTY = '0;

  // A slot is a candidate writer for addr only if it is live, writes, and is not $0.
  function automatic logic slot_hits(slot_t s, logic [REG_AW_MAX-1:0] addr);
    return s.valid && s.we && (s.rd != '0) && (s.rd == addr);
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Per-read-port forwarding select.
// Picks the youngest slot writing the requested register. If that writer has
// not yet produced its result, the port reports a hazard instead of falling
// back to an older (stale) writer.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  slot_t [NUM_STAGES:1]   i_slots,
  input  logic                   i_rd_en,
  input  logic [REG_AW_MAX-1:0]  i_addr,
  output logic [SELW-1:0]        o_fwd_sel,
  output logic                   o_hazard
);

  logic       w_hit;
  int         w_hit_stg;
  logic [2:0] w_hit_rdy;

  // Youngest-match search: scan oldest to youngest so the lowest k wins.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    w_hit     = 1'b0;
    w_hit_stg = 0;
    w_hit_rdy = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (slot_hits(i_slots[k], i_addr)) begin
        w_hit     = 1'b1;
        w_hit_stg = k;
        w_hit_rdy = i_slots[k].rdy_stg;
      end
    end
  end

  // Forward when the matched writer's result exists at its stage, else flag a hazard.
  always_comb begin
    o_fwd_sel = SELW'(FWD_SEL_RF);
    o_hazard  = 1'b0;
    if (i_rd_en && w_hit) begin
      if (w_hit_stg >= int'(w_hit_rdy)) begin
        o_fwd_sel = SELW'(w_hit_stg);
      end else begin
        o_hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// In-flight writer scoreboard for the 5-stage pipeline.
// Slot k mirrors the instruction in stage k after ID. Read ports get a
// forwarding select from the youngest matching slot; a not-yet-ready match
// requests a stall, which inserts a bubble into slot 1.
// Optional feature macro: FWD_STALL_CNT_EN adds a saturating stall_cnt output.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int NUM_RD     = 2,
  parameter int NUM_STAGES = 3,
  parameter int REG_AW     = 5,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     issue_valid,
  input  logic                     issue_we,
  input  logic [REG_AW-1:0]        issue_rd,
  input  logic [2:0]               issue_rdy_stg,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*REG_AW-1:0] rd_addr,
  input  logic                     pipe_hold,
  input  logic                     flush,
  output logic [NUM_RD*SELW-1:0]   fwd_sel,
  output logic                     stall
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]              stall_cnt
`endif
);

  slot_t [NUM_STAGES:1] r_slot;
  slot_t                w_issue_rec;
  logic [NUM_RD-1:0]    w_hazard;
  logic                 w_issue_ok;

  assign w_issue_rec = '{valid: 1'b1, we: issue_we,
                         rd: REG_AW_MAX'(issue_rd), rdy_stg: issue_rdy_stg};

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_port_sel #(
      .NUM_STAGES (NUM_STAGES),
      .SELW       (SELW)
    ) u_sel (
      .i_slots   (r_slot),
      .i_rd_en   (rd_en[i]),
      .i_addr    (REG_AW_MAX'(rd_addr[i*REG_AW +: REG_AW])),
      .o_fwd_sel (fwd_sel[i*SELW +: SELW]),
      .o_hazard  (w_hazard[i])
    );
  end

  // A flushed ID instruction is dead, so its operands cannot stall the pipe.
  assign stall      = (|w_hazard) && !flush;
  assign w_issue_ok = issue_valid && !stall && !flush;

  // Shift records down with the pipeline; hold freezes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the slot array is a handful of flops, not RAM, so it is reset;
      // a stale valid bit after reset would forward garbage.
      r_slot <= '0;
    end else if (!pipe_hold) begin
      // NOTE: non-blocking updates make every slot sample its pre-edge
      // neighbour; blocking ones would ripple a record through all slots.
      for (int k = NUM_STAGES; k >= 3; k--) begin
        r_slot[k] <= r_slot[k-1];
      end
      r_slot[2] <= flush ? SLOT_EMPTY : r_slot[1];
      r_slot[1] <= w_issue_ok ? w_issue_rec : SLOT_EMPTY;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Count cycles actually lost to stalls; frozen cycles are not stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall && !pipe_hold && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed bench for fwd_scoreboard: stimulus pushes hand-computed expected
// outputs into a queue, a negedge monitor pops and compares.
module tb_fwd_scoreboard;
  import fwd_pkg::*;

  localparam int NUM_RD     = 2;
  localparam int NUM_STAGES = 3;
  localparam int REG_AW     = 5;
  localparam int SELW       = $clog2(NUM_STAGES + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     issue_valid;
  logic                     issue_we;
  logic [REG_AW-1:0]        issue_rd;
  logic [2:0]               issue_rdy_stg;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*REG_AW-1:0] rd_addr;
  logic                     pipe_hold;
  logic                     flush;
  logic [NUM_RD*SELW-1:0]   fwd_sel;
  logic                     stall;
`ifdef FWD_STALL_CNT_EN
  logic [31:0]              stall_cnt;
`endif

  fwd_scoreboard #(
    .NUM_RD     (NUM_RD),
    .NUM_STAGES (NUM_STAGES),
    .REG_AW     (REG_AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_we      (issue_we),
    .issue_rd      (issue_rd),
    .issue_rdy_stg (issue_rdy_stg),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .pipe_hold     (pipe_hold),
    .flush         (flush),
    .fwd_sel       (fwd_sel),
    .stall         (stall)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic [NUM_RD*SELW-1:0] sel;
    logic                   stall;
    logic [31:0]            cnt;
  } exp_t;

  exp_t exp_q[$];
  logic probe = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expected record per probed cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (probe) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".sel"}, 32'(fwd_sel), 32'(e.sel));
        check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
`ifdef FWD_STALL_CNT_EN
        check({e.name, ".cnt"}, stall_cnt, e.cnt);
`endif
      end
    end
  end

  task automatic drive(input logic iv, input logic we, input logic [4:0] ird,
                       input logic [2:0] rdy, input logic [1:0] en,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic hold = 1'b0, input logic fl = 1'b0);
    issue_valid   = iv;
    issue_we      = we;
    issue_rd      = ird;
    issue_rdy_stg = rdy;
    rd_en         = en;
    rd_addr       = {a1, a0};
    pipe_hold     = hold;
    flush         = fl;
  endtask

  task automatic expect_out(input string name, input int s0, input int s1,
                            input logic st, input int cnt);
    exp_t e;
    e.name  = name;
    e.sel   = {SELW'(s1), SELW'(s0)};
    e.stall = st;
    e.cnt   = 32'(cnt);
    exp_q.push_back(e);
    probe = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    probe = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0);
      tick();
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b00, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd3, 5'd3);
    expect_out("reset", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    rst_n = 1'b1;

    // Back-to-back ALU ops: add $3; sub $4,$3,$5; then watch both age.
    drive(1'b1, 1'b1, 5'd3, RDY_ALU, 2'b11, 5'd1, 5'd2);
    expect_out("alu_add", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    drive(1'b1, 1'b1, 5'd4, RDY_ALU, 2'b11, 5'd3, 5'd5);
    expect_out("alu_sub", STG_EX, FWD_SEL_RF, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd3, 5'd4);
    expect_out("alu_age1", STG_MEM, STG_EX, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd3, 5'd4);
    expect_out("alu_age2", STG_WB, STG_MEM, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd3, 5'd4);
    expect_out("alu_retire", FWD_SEL_RF, STG_WB, 1'b0, 0);
    tick();

    // Load-use: lw $2; add $6,$2,$2 stalls one cycle then forwards from MEM.
    drive(1'b1, 1'b1, 5'd2, RDY_LOAD, 2'b01, 5'd9, 5'd0);
    expect_out("lw_issue", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd2, 5'd2);
    expect_out("lu_stall", FWD_SEL_RF, FWD_SEL_RF, 1'b1, 0);
    tick();
    drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd2, 5'd2);
    expect_out("lu_fwd", STG_MEM, STG_MEM, 1'b0, 1);
    tick();
    idle(3);

    // Double write of $7: youngest writer wins, never the slot-3 one.
    drive(1'b1, 1'b1, 5'd7, RDY_ALU, 2'b00, 5'd0, 5'd0);
    tick();
    idle(1);
    drive(1'b1, 1'b1, 5'd7, RDY_ALU, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd7, 5'd7);
    expect_out("dbl_alu", STG_EX, STG_EX, 1'b0, 1);
    tick();
    drive(1'b1, 1'b1, 5'd7, RDY_LOAD, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd9, RDY_ALU, 2'b11, 5'd7, 5'd8);
    expect_out("dbl_load_stall", FWD_SEL_RF, FWD_SEL_RF, 1'b1, 1);
    tick();
    drive(1'b1, 1'b1, 5'd9, RDY_ALU, 2'b11, 5'd7, 5'd8);
    expect_out("dbl_load_fwd", STG_MEM, FWD_SEL_RF, 1'b0, 2);
    tick();
    idle(3);

    // $0 written by every slot never forwards and never stalls.
    drive(1'b1, 1'b1, 5'd0, RDY_LOAD, 2'b11, 5'd0, 5'd0);
    expect_out("r0_a", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 2);
    tick();
    drive(1'b1, 1'b1, 5'd0, RDY_ALU, 2'b11, 5'd0, 5'd0);
    expect_out("r0_b", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 2);
    tick();
    drive(1'b1, 1'b1, 5'd0, RDY_LOAD, 2'b11, 5'd0, 5'd0);
    expect_out("r0_c", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 2);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd0, 5'd0);
    expect_out("r0_full", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 2);
    tick();
    idle(2);

    // pipe_hold for 4 cycles mid load-use: frozen slots, stall held, no counting.
    drive(1'b1, 1'b1, 5'd2, RDY_LOAD, 2'b00, 5'd0, 5'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd2, 5'd2, 1'b1);
      expect_out("hold_stall", FWD_SEL_RF, FWD_SEL_RF, 1'b1, 2);
      tick();
    end
    drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd2, 5'd2);
    expect_out("hold_release", FWD_SEL_RF, FWD_SEL_RF, 1'b1, 2);
    tick();
    drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd2, 5'd2);
    expect_out("hold_fwd", STG_MEM, STG_MEM, 1'b0, 3);
    tick();
    idle(3);

    // Flush during a load-use stall: stall drops, the load in slot 1 dies.
    drive(1'b1, 1'b1, 5'd5, RDY_LOAD, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd6, RDY_ALU, 2'b11, 5'd5, 5'd1, 1'b0, 1'b1);
    expect_out("flush_stall", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 3);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd5, 5'd6);
    expect_out("flush_slot2", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 3);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd5, 5'd6);
    expect_out("flush_slot3", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 3);
    tick();

    // Asynchronous reset mid-stream; port 1 disabled on a matching address.
    drive(1'b1, 1'b1, 5'd10, RDY_ALU, 2'b00, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd11, RDY_LOAD, 2'b01, 5'd10, 5'd10);
    expect_out("rd_en_off", STG_EX, FWD_SEL_RF, 1'b0, 3);
    tick();
    drive(1'b1, 1'b1, 5'd12, RDY_ALU, 2'b11, 5'd11, 5'd10);
    #1;
    rst_n = 1'b0;
    expect_out("async_rst", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    expect_out("rst_held", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd11, 5'd10);
    expect_out("rst_release", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();
    drive(1'b0, 1'b0, 5'd0, 3'd0, 2'b11, 5'd11, 5'd10);
    expect_out("rst_empty", FWD_SEL_RF, FWD_SEL_RF, 1'b0, 0);
    tick();

    idle(1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised forwarding and hazard unit for the 5-stage MIPS pipeline; it replaces the fixed EX/MEM/WB compare logic with an in-flight writer scoreboard. Every instruction leaving ID pushes a destination record that shifts down a NUM_STAGES-deep register in lock-step with the pipeline. From that record set the block produces a forwarding select for each of NUM_RD operand read ports and a load-use/multi-cycle stall request. It sits beside the ID stage and drives the ID- and EX-side operand muxes plus the PC/IF-ID hold logic.

## Interface
- NUM_RD, 2: number of operand read ports, each with its own select (min 1).
- NUM_STAGES, 3: pipeline stages after ID that hold results (EX=1, MEM=2, WB=3); min 2, max 7.
- REG_AW, 5: register address width.
- SELW, $clog2(NUM_STAGES+1): select field width.
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  ID instruction advances into EX this cycle.
- issue_we  in  1  issued instruction writes a register.
- issue_rd  in  REG_AW  issued destination register.
- issue_rdy_stg  in  3  first stage index whose output carries the result (1 = ALU, 2 = load, up to NUM_STAGES for multi-cycle).
- rd_en  in  NUM_RD  read port uses its register.
- rd_addr  in  NUM_RD*REG_AW  read port addresses, port i in bits [i*REG_AW +: REG_AW].
- pipe_hold  in  1  global freeze (memory wait); no slot moves.
- flush  in  1  kill the ID instruction and the record in slot 1.
- fwd_sel  out  NUM_RD*SELW  per port: 0 = register file, s = stage s output.
- stall  out  1  hold PC and IF/ID, insert a bubble into EX.
- stall_cnt  out  32  stall cycle count (only with FWD_STALL_CNT_EN).

## Operation
- Slot k (1..NUM_STAGES) holds {valid, we, rd, rdy_stg} for the instruction now in stage k.
- Records with rd==0 or we==0 never match.
- Each read port i: find the youngest (lowest k) valid matching slot.
  - No match: fwd_sel=0.
  - Match with k >= rdy_stg: fwd_sel=k.
  - Match with k < rdy_stg: fwd_sel=0 and the port raises a hazard.
- Older matches are ignored whenever a younger match exists, including when the younger one is not ready. Do not fall back to a stale value.
- stall = OR of port hazards, qualified by rd_en, and forced 0 while flush=1.
- A port with rd_en=0 gets fwd_sel=0 and raises no hazard.

## Timing
- Reset (asynchronous): all slots invalid; fwd_sel=0, stall=0, stall_cnt=0.
- fwd_sel and stall are combinational from the slot registers and the current rd_addr/rd_en. They add zero cycles of latency.
- Slot update on each clk edge:
  - pipe_hold=1: all slots hold. pipe_hold has priority over flush and issue.
  - Otherwise slot[k+1]<=slot[k] for k<NUM_STAGES; slot[NUM_STAGES] retires.
  - slot[1]<=issue record if issue_valid & ~stall & ~flush, else an invalid bubble.
- flush also invalidates the record currently in slot 1; it moves down as a bubble.
- A load issued at cycle t is in slot 1 at t+1. A dependent reader in ID at t+1 stalls exactly one cycle, then gets fwd_sel=2 at t+2.
- Issue and match in the same cycle: the new record is not visible until the next cycle. Reads in the same cycle see only existing slots.
- WB (slot NUM_STAGES) forwarding covers the write-then-read-same-cycle case. The register file needs no internal bypass.

## Configuration
- FWD_STALL_CNT_EN defined: stall_cnt increments on every clock with stall=1 and pipe_hold=0. It saturates at 32'hFFFF_FFFF and clears on reset.
- Not defined: the stall_cnt port is absent and no counter logic is built.

## Structure
- Shared package fwd_pkg holds:
  - the slot record struct {valid, we, rd, rdy_stg};
  - the constants FWD_SEL_RF=0, STG_EX=1, STG_MEM=2, STG_WB=3;
  - the rdy_stg encodings RDY_ALU=1, RDY_LOAD=2.
- One sub-module, fwd_port_sel, is instantiated NUM_RD times. It takes the slot vector and one address and returns fwd_sel and hazard.

## Test plan
- Back-to-back ALU ops, add $3 then sub $4,$3,$5: reader sees fwd_sel=1 on port 0 and stall=0.
- Load-use, lw $2 then add $6,$2,$2: stall=1 for one cycle with a bubble in slot 1, then fwd_sel=2 on both ports, and stall_cnt=1.
- Double write, $7 written by the instruction in slot 3 and by the one in slot 1: select is 1, never 3. Repeat with the slot-1 writer being a load: stall, not 3.
- Register $0 written by every slot with reads of $0: fwd_sel=0 and stall=0 throughout.
- pipe_hold=1 for 4 cycles mid-load-use: slots frozen, stall held, stall_cnt unchanged. Then flush during a stall: stall drops and slot 1 becomes invalid.
- Reset asserted asynchronously mid-stream: fwd_sel=0 and stall=0 immediately, all slots invalid on release.
